// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: 8N1 UART transmitter fed by a small byte FIFO.
// Frames leave back to back, with no idle gap, while the FIFO holds data.
module uart_tx_fifo #(
  parameter int unsigned CLKS_PER_BIT = 217,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic                         i_clock,
  input  logic                         i_reset_n,
  input  logic                         i_tx_dv,
  input  logic [7:0]                   i_tx_byte,
  output logic                         o_tx_ready,
  output logic                         o_tx_serial,
  output logic                         o_tx_active,
  output logic                         o_tx_done,
  output logic [$clog2(FIFO_DEPTH):0]  o_fifo_count
);

  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam int unsigned BAUD_W = $clog2(CLKS_PER_BIT);

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0]  CNT_ZERO  = '0;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [BAUD_W-1:0]  baud_q, baud_d;
  logic [2:0]         bit_q, bit_d;
  logic [7:0]         shift_q, shift_d;

  logic [7:0]         mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;

  logic               ready_q, ready_d;
  logic               serial_q, serial_d;
  logic               active_q, active_d;
  logic               done_q, done_d;

  logic               push;
  logic               pop;
  logic               baud_last;
  logic               has_data;

  assign push      = i_tx_dv && ready_q;
  assign baud_last = (baud_q == BAUD_LAST);
  assign has_data  = (count_q != CNT_ZERO);

  // Frame sequencer: pops the head byte on entry to START
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    pop     = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (has_data) begin
          pop     = 1'b1;
          shift_d = mem_q[rd_ptr_q];
          baud_d  = '0;
          state_d = S_START;
        end
      end
      S_START: begin
        if (baud_last) begin
          baud_d  = '0;
          bit_d   = 3'd0;
          state_d = S_DATA;
        end else begin
          baud_d  = baud_q + BAUD_W'(1);
        end
      end
      S_DATA: begin
        if (baud_last) begin
          baud_d = '0;
          if (bit_q == 3'd7) begin
            state_d = S_STOP;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      S_STOP: begin
        if (baud_last) begin
          baud_d = '0;
          if (has_data) begin
            pop     = 1'b1;
            shift_d = mem_q[rd_ptr_q];
            state_d = S_START;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        baud_d  = '0;
        bit_d   = 3'd0;
      end
    endcase
  end

  // FIFO bookkeeping; a write while full is rejected even if a pop happens
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
  end

  // Outputs are derived from next-state values so they register cleanly
  always_comb begin
    serial_d = 1'b1;
    active_d = (state_d != S_IDLE);
    done_d   = (state_d == S_STOP) && (baud_d == BAUD_LAST);
    ready_d  = (count_d != CNT_FULL);
    unique case (state_d)
      S_START: serial_d = 1'b0;
      S_DATA:  serial_d = shift_d[bit_d];
      default: serial_d = 1'b1;
    endcase
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q  <= S_IDLE;
      baud_q   <= '0;
      bit_q    <= 3'd0;
      shift_q  <= 8'h00;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ready_q  <= 1'b1;
      serial_q <= 1'b1;
      active_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ready_q  <= ready_d;
      serial_q <= serial_d;
      active_q <= active_d;
      done_q   <= done_d;
    end
  end

  // Storage needs no reset; occupancy is tracked by the pointers and count
  always_ff @(posedge i_clock) begin
    if (push) begin
      mem_q[wr_ptr_q] <= i_tx_byte;
    end
  end

  assign o_tx_ready   = ready_q;
  assign o_tx_serial  = serial_q;
  assign o_tx_active  = active_q;
  assign o_tx_done    = done_q;
  assign o_fifo_count = count_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: a serial-line receiver model decodes frames from a
// CLKS_PER_BIT=4 instance against a scoreboard; a second instance covers CLKS_PER_BIT=2.
module tb_uart_tx_fifo;

  localparam int C4     = 4;
  localparam int FRAME4 = 10 * C4;

  logic       clk = 1'b0;
  logic       rst4_n, rst2_n;
  logic       dv4, dv2;
  logic [7:0] byte4, byte2;
  logic       rdy4, ser4, act4, done4;
  logic       rdy2, ser2, act2, done2;
  logic [2:0] cnt4, cnt2;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  logic [7:0] exp_q[$];
  int         starts[$];
  int         frames_seen = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_tx_fifo #(.CLKS_PER_BIT(C4), .FIFO_DEPTH(4)) dut4 (
    .i_clock(clk), .i_reset_n(rst4_n), .i_tx_dv(dv4), .i_tx_byte(byte4),
    .o_tx_ready(rdy4), .o_tx_serial(ser4), .o_tx_active(act4),
    .o_tx_done(done4), .o_fifo_count(cnt4)
  );

  uart_tx_fifo #(.CLKS_PER_BIT(2), .FIFO_DEPTH(4)) dut2 (
    .i_clock(clk), .i_reset_n(rst2_n), .i_tx_dv(dv2), .i_tx_byte(byte2),
    .o_tx_ready(rdy2), .o_tx_serial(ser2), .o_tx_active(act2),
    .o_tx_done(done2), .o_fifo_count(cnt2)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Receiver model: samples at negedge, decodes mid-bit and checks frame shape
  initial begin : monitor
    logic       smp [FRAME4];
    logic       act_ok, aborted, shape_ok;
    int         done_n, done_at, k;
    logic [7:0] rx, exp_b;
    forever begin
      @(negedge clk);
      if (rst4_n === 1'b1 && ser4 === 1'b0) begin
        starts.push_back(cyc);
        aborted = 1'b0; act_ok = 1'b1; done_n = 0; done_at = -1; k = 0;
        while (k < FRAME4 && !aborted) begin
          if (k > 0) @(negedge clk);
          if (rst4_n !== 1'b1) begin
            aborted = 1'b1;
          end else begin
            smp[k] = ser4;
            if (act4 !== 1'b1) act_ok = 1'b0;
            if (done4 === 1'b1) begin done_n++; done_at = k; end
            k++;
          end
        end
        if (!aborted) begin
          frames_seen++;
          shape_ok = act_ok && (done_n == 1) && (done_at == FRAME4 - 1);
          for (int b = 0; b < 10; b++) begin
            for (int s = 0; s < C4; s++) begin
              if (smp[b*C4+s] !== smp[b*C4]) shape_ok = 1'b0;
            end
          end
          if (smp[0] !== 1'b0 || smp[9*C4] !== 1'b1) shape_ok = 1'b0;
          for (int b = 0; b < 8; b++) rx[b] = smp[(b+1)*C4 + C4/2];
          chk("frame_shape", 32'(shape_ok), 32'd1);
          if (exp_q.size() == 0) begin
            chk("unexpected_frame", 32'(rx), 32'hFFFF_FFFF);
          end else begin
            exp_b = exp_q.pop_front();
            chk("rx_byte", 32'(rx), 32'(exp_b));
          end
        end
      end
    end
  end

  task automatic push4(input logic [7:0] b, input logic accept);
    dv4 = 1'b1;
    byte4 = b;
    if (accept) exp_q.push_back(b);
    @(negedge clk);
    dv4 = 1'b0;
  endtask

  task automatic wait_frames(input int target, input int budget, input string name);
    int n = 0;
    while (frames_seen < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (frames_seen < target) chk(name, 32'(frames_seen), 32'(target));
  endtask

  typedef struct {
    logic       dv;
    logic [7:0] b;
    logic       acc;
    logic [2:0] cnt;
    logic       rdy;
  } vec_t;

  vec_t vecs [7];

  initial begin : main
    logic        line_ok;
    logic [19:0] got2, exp2, dmask;
    logic [7:0]  b2;
    logic        bv;
    int          base;

    vecs[0] = '{1'b1, 8'h10, 1'b1, 3'd1, 1'b1};
    vecs[1] = '{1'b1, 8'h11, 1'b1, 3'd1, 1'b1};
    vecs[2] = '{1'b1, 8'h12, 1'b1, 3'd2, 1'b1};
    vecs[3] = '{1'b1, 8'h13, 1'b1, 3'd3, 1'b1};
    vecs[4] = '{1'b1, 8'h14, 1'b1, 3'd4, 1'b0};
    vecs[5] = '{1'b1, 8'h15, 1'b0, 3'd4, 1'b0};
    vecs[6] = '{1'b0, 8'h00, 1'b0, 3'd4, 1'b0};

    rst4_n = 1'b0; rst2_n = 1'b0;
    dv4 = 1'b0; dv2 = 1'b0; byte4 = 8'h00; byte2 = 8'h00;
    repeat (3) @(negedge clk);
    rst4_n = 1'b1; rst2_n = 1'b1;
    @(negedge clk);

    chk("rst_serial", 32'(ser4), 32'd1);
    chk("rst_active", 32'(act4), 32'd0);
    chk("rst_done",   32'(done4), 32'd0);
    chk("rst_ready",  32'(rdy4), 32'd1);
    chk("rst_count",  32'(cnt4), 32'd0);
    chk("rst2_serial", 32'(ser2), 32'd1);
    chk("rst2_count",  32'(cnt2), 32'd0);

    // Single frame 0xA5
    push4(8'hA5, 1'b1);
    chk("a5_count_after_write", 32'(cnt4), 32'd1);
    wait_frames(1, FRAME4 + 10, "a5_frame_timeout");
    @(negedge clk);
    chk("a5_idle_serial", 32'(ser4), 32'd1);
    chk("a5_idle_active", 32'(act4), 32'd0);

    // Three back-to-back frames
    starts.delete();
    push4(8'h01, 1'b1);
    push4(8'h02, 1'b1);
    push4(8'h03, 1'b1);
    wait_frames(4, 3*FRAME4 + 10, "b2b_frame_timeout");
    chk("b2b_starts", 32'(starts.size()), 32'd3);
    if (starts.size() == 3) begin
      chk("b2b_gap1", 32'(starts[1] - starts[0]), 32'(FRAME4));
      chk("b2b_gap2", 32'(starts[2] - starts[1]), 32'(FRAME4));
    end
    @(negedge clk);
    chk("b2b_count_end", 32'(cnt4), 32'd0);
    chk("b2b_idle_active", 32'(act4), 32'd0);

    // FIFO fill / overflow table
    for (int i = 0; i < 7; i++) begin
      dv4 = vecs[i].dv;
      byte4 = vecs[i].b;
      if (vecs[i].acc) exp_q.push_back(vecs[i].b);
      @(negedge clk);
      chk($sformatf("fill%0d_count", i), 32'(cnt4), 32'(vecs[i].cnt));
      chk($sformatf("fill%0d_ready", i), 32'(rdy4), 32'(vecs[i].rdy));
    end
    dv4 = 1'b0;
    wait_frames(9, 5*FRAME4 + 10, "fill_frame_timeout");
    @(negedge clk);
    chk("fill_count_end", 32'(cnt4), 32'd0);

    // Loopback-style byte check
    push4(8'h00, 1'b1);
    push4(8'hFF, 1'b1);
    push4(8'h3C, 1'b1);
    wait_frames(12, 3*FRAME4 + 10, "loop_frame_timeout");
    @(negedge clk);
    chk("loop_frames", 32'(frames_seen), 32'd12);

    // Reset during data bit 3 of 0x37, with two bytes still queued
    push4(8'h37, 1'b1);
    push4(8'h44, 1'b1);
    push4(8'h55, 1'b1);
    repeat (16) @(negedge clk);
    chk("mid_pre_serial", 32'(ser4), 32'd0);
    chk("mid_pre_active", 32'(act4), 32'd1);
    chk("mid_pre_count",  32'(cnt4), 32'd2);
    #2 rst4_n = 1'b0;
    #1;
    chk("mid_rst_serial", 32'(ser4), 32'd1);
    chk("mid_rst_active", 32'(act4), 32'd0);
    chk("mid_rst_count",  32'(cnt4), 32'd0);
    exp_q.delete();
    @(negedge clk);
    rst4_n = 1'b1;
    line_ok = 1'b1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (ser4 !== 1'b1 || act4 !== 1'b0) line_ok = 1'b0;
    end
    chk("post_rst_line_high", 32'(line_ok), 32'd1);
    chk("post_rst_count", 32'(cnt4), 32'd0);

    // CLKS_PER_BIT=2 boundary with 0x80
    b2 = 8'h80;
    dv2 = 1'b1; byte2 = b2;
    @(negedge clk);
    dv2 = 1'b0;
    chk("c2_count_after_write", 32'(cnt2), 32'd1);
    chk("c2_line_still_high",   32'(ser2), 32'd1);
    @(negedge clk);
    chk("c2_popped_count", 32'(cnt2), 32'd0);
    for (int b = 0; b < 10; b++) begin
      bv = (b == 0) ? 1'b0 : (b == 9) ? 1'b1 : b2[b-1];
      exp2[2*b] = bv;
      exp2[2*b+1] = bv;
    end
    got2 = '0; dmask = '0;
    for (int k = 0; k < 20; k++) begin
      if (k > 0) @(negedge clk);
      got2[k] = ser2;
      dmask[k] = done2;
    end
    chk("c2_waveform", 32'(got2), 32'(exp2));
    chk("c2_done_pos", 32'(dmask), 32'h0008_0000);
    @(negedge clk);
    chk("c2_idle_serial", 32'(ser2), 32'd1);
    chk("c2_idle_active", 32'(act2), 32'd0);

    base = frames_seen;
    repeat (5) @(negedge clk);
    chk("no_stray_frames", 32'(frames_seen), 32'(base));
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1);
  end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
- 8N1 UART transmitter with a small input FIFO.
- It is the transmit-side counterpart of the team's uart_rx, running on the same board clock and baud parameterisation.
- It accepts bytes from on-chip logic (e.g. an echo path or a status reporter) and serialises them on the FPGA UART TX pin.
- Back-to-back frames are sent with no idle gap while the FIFO holds data.

Parameters:
CLKS_PER_BIT, 217, clock cycles per UART bit (25 MHz / 115200); legal values >= 2
FIFO_DEPTH, 4, byte entries in the input FIFO; power of two, >= 2

Ports:
i_clock  input  1  system clock; all logic is on its rising edge
i_reset_n  input  1  asynchronous, active-low reset
i_tx_dv  input  1  write strobe; i_tx_byte is pushed when i_tx_dv && o_tx_ready
i_tx_byte  input  8  byte to transmit
o_tx_ready  output  1  high when the FIFO is not full
o_tx_serial  output  1  UART TX line; idles high
o_tx_active  output  1  high while a frame (start..stop) is on the line
o_tx_done  output  1  one-cycle pulse on the last cycle of each stop bit
o_fifo_count  output  clog2(FIFO_DEPTH)+1  bytes currently held in the FIFO (excludes the byte being shifted)

Behaviour:
- Reset state (asynchronous on i_reset_n low):
  - o_tx_serial=1, o_tx_active=0, o_tx_done=0, o_tx_ready=1, o_fifo_count=0.
  - FSM=IDLE; FIFO pointers, baud counter and bit index cleared.
- Reset mid-frame: the line returns high immediately; the frame and all queued bytes are discarded.
- FIFO:
  - Synchronous write and read pointers with wrap at FIFO_DEPTH.
  - o_tx_ready = !full, registered from count.
  - A write with the FIFO full is dropped silently; state is unchanged.
  - A write while full is rejected even if a pop occurs in the same cycle.
  - Simultaneous push and pop leaves the count unchanged; the data ordering is preserved.
- FSM states are IDLE, START, DATA, STOP.
  - IDLE: o_tx_serial=1. If count>0, pop the head byte into the shift register on this edge and go to START.
  - START: o_tx_serial=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA: drive shift[bit index], LSB first, for CLKS_PER_BIT cycles per bit. After bit 7 go to STOP.
  - STOP: o_tx_serial=1 for CLKS_PER_BIT cycles. o_tx_done=1 on the final cycle. Then:
    - if count>0, pop and go directly to START (no idle cycles between frames);
    - otherwise go to IDLE.
- o_tx_active is high in START, DATA and STOP; low in IDLE.
- Latency: for a write sampled at edge E into an empty FIFO with the FSM in IDLE:
  - count=1 after E;
  - pop at E+1, when o_tx_serial goes low;
  - frame length is exactly 10*CLKS_PER_BIT cycles from the falling edge of the line to the end of the stop bit.
- Baud counter: width clog2(CLKS_PER_BIT), counts 0..CLKS_PER_BIT-1 and wraps. The bit index is 3 bits.
- All outputs are registered; o_tx_serial has no combinational path from the inputs.

Test Plan:
- CLKS_PER_BIT=4: write 0xA5 once.
  - Line low 4 cycles, then bits 1,0,1,0,0,1,0,1 (4 cycles each), then high 4 cycles.
  - o_tx_done pulses once, 40 cycles after the line falls; o_tx_active high for exactly 40 cycles.
- CLKS_PER_BIT=4: write 0x01, 0x02, 0x03 on consecutive cycles.
  - Three contiguous 40-cycle frames with no idle gap; three o_tx_done pulses 40 cycles apart; o_fifo_count ends at 0.
- FIFO_DEPTH=4, idle: assert i_tx_dv for 6 consecutive cycles with bytes 0x10..0x15.
  - o_fifo_count goes 1,1,2,3,4; o_tx_ready drops; 0x15 is dropped.
  - Exactly 0x10..0x14 are transmitted, in order.
- Reset mid-frame: pull i_reset_n low during DATA bit 3.
  - o_tx_serial=1 and o_tx_active=0 immediately, without waiting for a clock.
  - After release with no writes, the line stays high and o_fifo_count=0.
- Loopback to uart_rx with matching CLKS_PER_BIT: send 0x00, 0xFF, 0x3C.
  - The receiver o_rx_byte reports the same values in order, with one o_rx_dv per byte.
- Boundary: with CLKS_PER_BIT=2, write 0x80.
  - Each bit lasts exactly 2 cycles and bit 7 (1) is last before the stop bit.
